mips_multicycle_core: RTL and testbench

//  Multicycle MIPS-subset CPU core, successor to the single-cycle computer top.
//  One shared ALU, a single unified memory port with req/ready handshake, FSM control.

---
 rtl/mips_pkg.sv | 63 ++++++
 rtl/mips_regfile.sv | 31 +++
 rtl/mips_multicycle_core.sv | 226 ++++++++++++++++++++++
 tb/tb_mips_multicycle_core.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS-subset core: opcodes, functs, ALU controls,
// FSM state codes and small datapath helpers.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef logic [2:0] alu_ctl_t;
  localparam alu_ctl_t ALU_ADD = 3'd0;
  localparam alu_ctl_t ALU_SUB = 3'd1;
  localparam alu_ctl_t ALU_AND = 3'd2;
  localparam alu_ctl_t ALU_OR  = 3'd3;
  localparam alu_ctl_t ALU_SLT = 3'd4;
  localparam alu_ctl_t ALU_NOR = 3'd5;

  typedef logic [3:0] state_t;
  localparam state_t S_FETCH  = 4'd0;
  localparam state_t S_DECODE = 4'd1;
  localparam state_t S_MEMADR = 4'd2;
  localparam state_t S_MEMRD  = 4'd3;
  localparam state_t S_MEMWB  = 4'd4;
  localparam state_t S_MEMWR  = 4'd5;
  localparam state_t S_EXEC   = 4'd6;
  localparam state_t S_ALUWB  = 4'd7;
  localparam state_t S_ADDIEX = 4'd8;
  localparam state_t S_ADDIWB = 4'd9;
  localparam state_t S_BRANCH = 4'd10;
  localparam state_t S_JUMP   = 4'd11;
  localparam state_t S_TRAP   = 4'd12;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic [31:0] alu_eval(input alu_ctl_t ctl, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [31:0] y;
    case (ctl)
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_SLT: y = {31'b0, ($signed(a) < $signed(b))};
      ALU_NOR: y = ~(a | b);
      default: y = a + b;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/mips_regfile.sv
// NREGS x 32 register file: two asynchronous reads, one synchronous write, R0 reads as zero.
module mips_regfile
  import mips_pkg::*;
#(
  parameter int unsigned NREGS = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     we_i,
  input  logic [$clog2(NREGS)-1:0] waddr_i,
  input  logic [31:0]              wdata_i,
  input  logic [$clog2(NREGS)-1:0] raddr1_i,
  input  logic [$clog2(NREGS)-1:0] raddr2_i,
  output logic [31:0]              rdata1_o,
  output logic [31:0]              rdata2_o
);

  logic [31:0] regs_q [NREGS];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = (raddr1_i == '0) ? '0 : regs_q[raddr1_i];
  assign rdata2_o = (raddr2_i == '0) ? '0 : regs_q[raddr2_i];

endmodule

// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS-subset core with one shared ALU and a single req/ready memory port.
// Define MIPS_EXT_OPS_EN to add bne, andi, ori and R-type nor (otherwise they trap).
module mips_multicycle_core
  import mips_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       NREGS    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] pc_dbg,
  output logic              trap
);

  localparam int unsigned RIDX_W = $clog2(NREGS);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       ir_q, ir_d, a_q, a_d, b_q, b_d, alu_q, alu_d, mdr_q, mdr_d;
  logic              trap_q, trap_d;

  logic [5:0]        op, funct;
  logic [31:0]       pc32, imm_sx, imm_ext, jtarget;
  logic [31:0]       alu_a, alu_b, alu_y;
  alu_ctl_t          alu_ctl, funct_ctl, imm_ctl;
  logic              funct_ok, br_take;
  logic              rf_we;
  logic [RIDX_W-1:0] rs, rt, rd, rf_waddr;
  logic [31:0]       rf_wdata, rf_rd1, rf_rd2;
  logic [ADDR_W-1:0] addr_sel;

  assign op      = ir_q[31:26];
  assign funct   = ir_q[5:0];
  assign rs      = ir_q[21 +: RIDX_W];
  assign rt      = ir_q[16 +: RIDX_W];
  assign rd      = ir_q[11 +: RIDX_W];
  assign pc32    = 32'(pc_q);
  assign imm_sx  = sext16(ir_q[15:0]);
  assign jtarget = {pc32[31:28], ir_q[25:0], 2'b00};

  mips_regfile #(.NREGS(NREGS)) u_regfile (
    .clock    (clock),
    .reset    (reset),
    .we_i     (rf_we),
    .waddr_i  (rf_waddr),
    .wdata_i  (rf_wdata),
    .raddr1_i (rs),
    .raddr2_i (rt),
    .rdata1_o (rf_rd1),
    .rdata2_o (rf_rd2)
  );

  always_comb begin
    funct_ok  = 1'b1;
    funct_ctl = ALU_ADD;
    case (funct)
      FN_ADD: funct_ctl = ALU_ADD;
      FN_SUB: funct_ctl = ALU_SUB;
      FN_AND: funct_ctl = ALU_AND;
      FN_OR:  funct_ctl = ALU_OR;
      FN_SLT: funct_ctl = ALU_SLT;
`ifdef MIPS_EXT_OPS_EN
      FN_NOR: funct_ctl = ALU_NOR;
`endif
      default: funct_ok = 1'b0;
    endcase
  end

  always_comb begin
    imm_ext = imm_sx;
    imm_ctl = ALU_ADD;
`ifdef MIPS_EXT_OPS_EN
    if (op == OP_ANDI) begin
      imm_ext = {16'b0, ir_q[15:0]};
      imm_ctl = ALU_AND;
    end else if (op == OP_ORI) begin
      imm_ext = {16'b0, ir_q[15:0]};
      imm_ctl = ALU_OR;
    end
`endif
  end

  // Shared ALU operand selection; BRANCH compares via subtraction and a zero test.
  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_ctl = ALU_ADD;
    case (state_q)
      S_FETCH:  begin alu_a = pc32; alu_b = 32'd4; end
      S_DECODE: begin alu_a = pc32; alu_b = {imm_sx[29:0], 2'b00}; end
      S_MEMADR: begin alu_a = a_q;  alu_b = imm_sx; end
      S_ADDIEX: begin alu_a = a_q;  alu_b = imm_ext; alu_ctl = imm_ctl; end
      S_EXEC:   begin alu_a = a_q;  alu_b = b_q; alu_ctl = funct_ctl; end
      S_BRANCH: begin alu_a = a_q;  alu_b = b_q; alu_ctl = ALU_SUB; end
      default: ;
    endcase
  end

  assign alu_y = alu_eval(alu_ctl, alu_a, alu_b);

`ifdef MIPS_EXT_OPS_EN
  assign br_take = (op == OP_BNE) ? (alu_y != '0) : (alu_y == '0);
`else
  assign br_take = (alu_y == '0);
`endif

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    alu_d    = alu_q;
    mdr_d    = mdr_q;
    trap_d   = trap_q;
    rf_we    = 1'b0;
    rf_waddr = rt;
    rf_wdata = alu_q;
    case (state_q)
      S_FETCH: if (mem_ready) begin
        ir_d    = mem_rdata;
        pc_d    = ADDR_W'(alu_y);
        state_d = S_DECODE;
      end
      S_DECODE: begin
        a_d   = rf_rd1;
        b_d   = rf_rd2;
        alu_d = alu_y;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = funct_ok ? S_EXEC : S_TRAP;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
`ifdef MIPS_EXT_OPS_EN
          OP_BNE:           state_d = S_BRANCH;
          OP_ANDI, OP_ORI:  state_d = S_ADDIEX;
`endif
          default:      state_d = S_TRAP;
        endcase
        trap_d = (state_d == S_TRAP);
      end
      S_MEMADR: begin
        alu_d   = alu_y;
        state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: if (mem_ready) begin
        mdr_d   = mem_rdata;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        rf_we    = 1'b1;
        rf_wdata = mdr_q;
        state_d  = S_FETCH;
      end
      S_MEMWR: if (mem_ready) state_d = S_FETCH;
      S_EXEC: begin
        alu_d   = alu_y;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        rf_we    = 1'b1;
        rf_waddr = rd;
        state_d  = S_FETCH;
      end
      S_ADDIEX: begin
        alu_d   = alu_y;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        rf_we   = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        if (br_take) pc_d = ADDR_W'(alu_q);
        state_d = S_FETCH;
      end
      S_JUMP: begin
        pc_d    = ADDR_W'(jtarget);
        state_d = S_FETCH;
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      alu_q   <= '0;
      mdr_q   <= '0;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      alu_q   <= alu_d;
      mdr_q   <= mdr_d;
      trap_q  <= trap_d;
    end
  end

  // Request is gated by reset so a reset cycle never shows an access on the port.
  assign mem_req   = !reset && ((state_q == S_FETCH) || (state_q == S_MEMRD) ||
                                (state_q == S_MEMWR));
  assign mem_we    = !reset && (state_q == S_MEMWR);
  assign addr_sel  = (state_q == S_FETCH) ? pc_q : alu_q[ADDR_W-1:0];
  assign mem_addr  = addr_sel & ~ADDR_W'(32'd3);
  assign mem_wdata = b_q;
  assign pc_dbg    = pc_q;
  assign trap      = trap_q;

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed self-checking bench for mips_multicycle_core with a wait-state memory model.
module tb_mips_multicycle_core;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req, mem_we, mem_ready, trap;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_dbg;

  always #5 clock = ~clock;

  mips_multicycle_core #(.ADDR_W(32), .NREGS(32), .RESET_PC(32'h0)) dut (
    .clock     (clock),
    .reset     (reset),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .pc_dbg    (pc_dbg),
    .trap      (trap)
  );

  logic [31:0] mem [0:255];
  int          wait_n = 0, wcnt = 0, cyc = 0, unstable = 0, stalls = 0;
  int          rd_addr[$], rd_cyc[$], st_addr[$], st_data[$];
  logic        pend = 1'b0, h_we = 1'b0;
  logic [31:0] h_addr = '0, h_wdata = '0;
  int          n_checks = 0, n_pass = 0, n_fail = 0;

  assign mem_ready = (wcnt >= wait_n);
  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clock) begin
    if (reset) begin
      wcnt <= 0;
      cyc  <= 0;
      pend <= 1'b0;
    end else begin
      cyc <= cyc + 1;
      if (mem_req && !mem_ready) begin
        wcnt   <= wcnt + 1;
        stalls <= stalls + 1;
        if (pend && (mem_addr !== h_addr || mem_we !== h_we || (mem_we && mem_wdata !== h_wdata)))
          unstable <= unstable + 1;
        pend    <= 1'b1;
        h_addr  <= mem_addr;
        h_we    <= mem_we;
        h_wdata <= mem_wdata;
      end else begin
        wcnt <= 0;
        pend <= 1'b0;
      end
      if (mem_req && mem_ready) begin
        if (mem_we) begin
          mem[mem_addr[9:2]] <= mem_wdata;
          st_addr.push_back(int'(mem_addr));
          st_data.push_back(int'(mem_wdata));
        end else begin
          rd_addr.push_back(int'(mem_addr));
          rd_cyc.push_back(cyc);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int nth_read(input int a, input int n);
    int k = 0;
    foreach (rd_addr[i]) begin
      if (rd_addr[i] == a) begin
        if (k == n) return rd_cyc[i];
        k++;
      end
    end
    return -1;
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
  endtask

  task automatic load_prog_a();
    clear_mem();
    mem[0]  = 32'h20010005;  // addi $1,$0,5
    mem[1]  = 32'h2002FFFD;  // addi $2,$0,-3
    mem[2]  = 32'h00221820;  // add  $3,$1,$2
    mem[3]  = 32'h0041202A;  // slt  $4,$2,$1
    mem[4]  = 32'hAC030008;  // sw   $3,8($0)
    mem[5]  = 32'h8C050008;  // lw   $5,8($0)
    mem[6]  = 32'hAC040084;  // sw   $4,0x84($0)
    mem[7]  = 32'hAC050088;  // sw   $5,0x88($0)
    mem[8]  = 32'h00223022;  // sub  $6,$1,$2
    mem[9]  = 32'h00223825;  // or   $7,$1,$2
    mem[10] = 32'hAC06008C;  // sw   $6,0x8C($0)
    mem[11] = 32'hAC070090;  // sw   $7,0x90($0)
    mem[12] = 32'h10000001;  // beq  $0,$0,+1
    mem[13] = 32'hFC000000;  // illegal, must be skipped
    mem[14] = 32'h10220001;  // beq  $1,$2,+1 (not taken)
    mem[15] = 32'h08000040;  // j    0x40 -> 0x100
    mem[64] = 32'h1000FFFF;  // beq  $0,$0,-1 at 0x100
  endtask

  task automatic apply_reset(input int n);
    reset = 1'b1;
    repeat (n) @(negedge clock);
    check("rst_req", {31'b0, mem_req}, 32'd0);
    check("rst_we", {31'b0, mem_we}, 32'd0);
    rd_addr.delete(); rd_cyc.delete(); st_addr.delete(); st_data.delete();
    stalls   = 0;
    unstable = 0;
    reset    = 1'b0;
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int seen;

    // Program A, zero wait states
    load_prog_a();
    wait_n = 0;
    apply_reset(3);
    check("post_rst_addr", mem_addr, 32'h0);
    check("post_rst_req", {31'b0, mem_req}, 32'd1);
    check("post_rst_pc", pc_dbg, 32'h0);
    check("post_rst_trap", {31'b0, trap}, 32'd0);
    repeat (80) @(negedge clock);
    check("cpi_addi", nth_read(32'h04, 0) - nth_read(32'h00, 0), 4);
    check("cpi_add", nth_read(32'h0C, 0) - nth_read(32'h08, 0), 4);
    check("cpi_sw", nth_read(32'h14, 0) - nth_read(32'h10, 0), 4);
    check("cpi_lw", nth_read(32'h18, 0) - nth_read(32'h14, 0), 5);
    check("cpi_beq_taken", nth_read(32'h38, 0) - nth_read(32'h30, 0), 3);
    check("cpi_beq_nt", nth_read(32'h3C, 0) - nth_read(32'h38, 0), 3);
    check("cpi_j", nth_read(32'h100, 0) - nth_read(32'h3C, 0), 3);
    check("loop_period", nth_read(32'h100, 1) - nth_read(32'h100, 0), 3);
    check("skip_0x34", nth_read(32'h34, 0), 32'hFFFFFFFF);
    check("no_fetch_0x40", nth_read(32'h40, 0), 32'hFFFFFFFF);
    check("store_count", st_addr.size(), 5);
    check("sw_addr", st_addr[0], 32'h8);
    check("sw_wdata", st_data[0], 32'h2);
    check("add_r3", mem[2], 32'h2);
    check("slt_r4", mem[33], 32'h1);
    check("lw_r5", mem[34], 32'h2);
    check("sub_r6", mem[35], 32'h8);
    check("or_r7", mem[36], 32'hFFFFFFFD);
    check("a_trap", {31'b0, trap}, 32'd0);

    // Program A, every access waits 3 cycles
    load_prog_a();
    wait_n = 3;
    apply_reset(2);
    repeat (200) @(negedge clock);
    check("w3_cpi_addi", nth_read(32'h04, 0) - nth_read(32'h00, 0), 7);
    check("w3_cpi_sw", nth_read(32'h14, 0) - nth_read(32'h10, 0), 10);
    check("w3_cpi_lw", nth_read(32'h18, 0) - nth_read(32'h14, 0), 11);
    check("w3_cpi_beq", nth_read(32'h38, 0) - nth_read(32'h30, 0), 6);
    check("w3_sw_addr", st_addr[0], 32'h8);
    check("w3_sw_wdata", st_data[0], 32'h2);
    check("w3_lw_r5", mem[34], 32'h2);
    check("w3_or_r7", mem[36], 32'hFFFFFFFD);
    check("w3_stalled", {31'b0, (stalls > 0)}, 32'd1);
    check("w3_stable", unstable, 0);

    // Illegal opcode traps and stays quiet until reset
    clear_mem();
    mem[0] = 32'hFC000000;
    wait_n = 0;
    apply_reset(2);
    @(negedge clock);
    check("trap_in_decode", {31'b0, trap}, 32'd0);
    @(negedge clock);
    check("trap_set", {31'b0, trap}, 32'd1);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (mem_req) cnt++;
    end
    check("trap_no_req", cnt, 0);
    check("trap_pc", pc_dbg, 32'h4);
    apply_reset(1);
    check("trap_cleared", {31'b0, trap}, 32'd0);
    check("trap_refetch_addr", mem_addr, 32'h0);
    check("trap_refetch_req", {31'b0, mem_req}, 32'd1);

    // ori: extension build executes it, default build traps
    clear_mem();
    mem[0]  = 32'h3401FFFF;  // ori $1,$0,0xFFFF
    mem[1]  = 32'hAC010080;  // sw  $1,0x80($0)
    mem[2]  = 32'h1000FFFF;
    mem[32] = 32'hDEADBEEF;
    apply_reset(2);
    repeat (30) @(negedge clock);
`ifdef MIPS_EXT_OPS_EN
    check("ori_result", mem[32], 32'h0000FFFF);
    check("ori_trap", {31'b0, trap}, 32'd0);
`else
    check("ori_trap", {31'b0, trap}, 32'd1);
    check("ori_no_store", mem[32], 32'hDEADBEEF);
`endif

    // Reset while a store is stalled
    clear_mem();
    mem[0]  = 32'hAC000080;  // sw $0,0x80($0)
    mem[1]  = 32'h1000FFFF;
    mem[32] = 32'hDEADBEEF;
    wait_n  = 5;
    apply_reset(2);
    seen = 0;
    for (int i = 0; i < 30 && seen == 0; i++) begin
      @(negedge clock);
      if (mem_req && mem_we) seen = 1;
    end
    check("memwr_reached", seen, 1);
    reset = 1'b1;
    @(negedge clock);
    check("midrst_we", {31'b0, mem_we}, 32'd0);
    check("midrst_req", {31'b0, mem_req}, 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("midrst_no_write", mem[32], 32'hDEADBEEF);
    check("midrst_no_store", st_addr.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
